// File: rtl/dsm_channel_meter.sv
// dsm_channel_meter: single-channel pulse measurement engine.
// Times one high + low period of a synchronised pin, then derives duty in per-mille
// with a restoring serial divider and holds the results until the request drops.
module dsm_channel_meter #(
    parameter int unsigned CNT_W       = 16,
    parameter logic [31:0] TIMEOUT_CYC = 32'd50_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             measure_start,
    input  logic             measure_pin,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] low_time,
    output logic [CNT_W-1:0] period_time,
    output logic [15:0]      duty_cycle,
    output logic             measure_done,
    output logic             measure_timeout,
    output logic             busy
);
    localparam int unsigned DivdW = CNT_W + 10;  // wide enough for high_cnt * 1000
    localparam int unsigned DivsW = CNT_W + 1;   // unsaturated high + low
    localparam int unsigned StepW = $clog2(DivdW);

    typedef enum logic [2:0] {StIdle, StWaitRise, StHigh, StLow, StDiv, StDone} state_e;

    state_e           state_q, state_d;
    logic             pin_m_q, pin_s_q, pin_d_q;
    logic             rise, fall;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d, low_cnt_q, low_cnt_d;
    logic [31:0]      tmo_q, tmo_d;
    logic             tmo_hit;
    logic [DivdW-1:0] dq_q, dq_d, dq_next;
    logic [DivsW-1:0] rem_q, rem_d, rem_sub, divisor;
    logic [DivsW:0]   trial;
    logic             qbit;
    logic [StepW-1:0] step_q, step_d;
    logic [CNT_W-1:0] high_res_q, high_res_d, low_res_q, low_res_d, per_res_q, per_res_d;
    logic [15:0]      duty_res_q, duty_res_d;
    logic             tmo_res_q, tmo_res_d;
    logic             go_tmo, go_done;

    assign rise = pin_s_q & ~pin_d_q;
    assign fall = ~pin_s_q & pin_d_q;

    // Any edge restarts the timeout window, and an edge always beats a timeout.
    assign tmo_hit = ~(rise | fall) && (tmo_q >= TIMEOUT_CYC - 32'd1);

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    assign divisor = {1'b0, high_cnt_q} + {1'b0, low_cnt_q};
    assign trial   = {rem_q, dq_q[DivdW-1]};
    assign qbit    = trial >= {1'b0, divisor};
    assign rem_sub = trial[DivsW-1:0] - divisor;
    assign dq_next = {dq_q[DivdW-2:0], qbit};

    assign high_time       = high_res_q;
    assign low_time        = low_res_q;
    assign period_time     = per_res_q;
    assign duty_cycle      = duty_res_q;
    assign measure_timeout = tmo_res_q;
    assign measure_done    = (state_q == StDone);
    assign busy            = (state_q != StIdle) && (state_q != StDone);

    // Two-flop synchroniser plus one delay stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pin_m_q <= 1'b0;
            pin_s_q <= 1'b0;
            pin_d_q <= 1'b0;
        end else begin
            pin_m_q <= measure_pin;
            pin_s_q <= pin_m_q;
            pin_d_q <= pin_s_q;
        end
    end

    // State, counters, divider and held results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            high_cnt_q <= '0;
            low_cnt_q  <= '0;
            tmo_q      <= '0;
            dq_q       <= '0;
            rem_q      <= '0;
            step_q     <= '0;
            high_res_q <= '0;
            low_res_q  <= '0;
            per_res_q  <= '0;
            duty_res_q <= '0;
            tmo_res_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            high_cnt_q <= high_cnt_d;
            low_cnt_q  <= low_cnt_d;
            tmo_q      <= tmo_d;
            dq_q       <= dq_d;
            rem_q      <= rem_d;
            step_q     <= step_d;
            high_res_q <= high_res_d;
            low_res_q  <= low_res_d;
            per_res_q  <= per_res_d;
            duty_res_q <= duty_res_d;
            tmo_res_q  <= tmo_res_d;
        end
    end

    // Next-state logic; a dropped request wins over edges and timeouts.
    always_comb begin
        state_d    = state_q;
        high_cnt_d = high_cnt_q;
        low_cnt_d  = low_cnt_q;
        tmo_d      = tmo_q;
        dq_d       = dq_q;
        rem_d      = rem_q;
        step_d     = step_q;
        high_res_d = high_res_q;
        low_res_d  = low_res_q;
        per_res_d  = per_res_q;
        duty_res_d = duty_res_q;
        tmo_res_d  = tmo_res_q;
        go_tmo     = 1'b0;
        go_done    = 1'b0;

        case (state_q)
            StIdle: begin
                if (measure_start) begin
                    state_d    = StWaitRise;
                    high_cnt_d = '0;
                    low_cnt_d  = '0;
                    tmo_d      = '0;
                end
            end
            StWaitRise: begin
                tmo_d = (rise | fall) ? 32'd0 : tmo_q + 32'd1;
                if (!measure_start) begin
                    state_d = StIdle;
                end else if (rise) begin
                    state_d    = StHigh;
                    high_cnt_d = CNT_W'(1);
                end else if (tmo_hit) begin
                    go_tmo = 1'b1;
                end
            end
            StHigh: begin
                tmo_d = (rise | fall) ? 32'd0 : tmo_q + 32'd1;
                if (!measure_start) begin
                    state_d = StIdle;
                end else if (fall) begin
                    state_d   = StLow;
                    low_cnt_d = CNT_W'(1);
                end else if (tmo_hit) begin
                    go_tmo = 1'b1;
                end else if (!(&high_cnt_q)) begin
                    high_cnt_d = high_cnt_q + CNT_W'(1);
                end
            end
            StLow: begin
                tmo_d = (rise | fall) ? 32'd0 : tmo_q + 32'd1;
                if (!measure_start) begin
                    state_d = StIdle;
                end else if (rise) begin
                    state_d = StDiv;
                    dq_d    = DivdW'(high_cnt_q) * DivdW'(1000);
                    rem_d   = '0;
                    step_d  = '0;
                end else if (tmo_hit) begin
                    go_tmo = 1'b1;
                end else if (!(&low_cnt_q)) begin
                    low_cnt_d = low_cnt_q + CNT_W'(1);
                end
            end
            StDiv: begin
                if (!measure_start) begin
                    state_d = StIdle;
                end else begin
                    dq_d   = dq_next;
                    rem_d  = qbit ? rem_sub : trial[DivsW-1:0];
                    step_d = step_q + StepW'(1);
                    if (step_q == StepW'(DivdW - 1)) begin
                        go_done = 1'b1;
                    end
                end
            end
            StDone: begin
                if (!measure_start) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (go_tmo) begin
            state_d    = StDone;
            high_res_d = '0;
            low_res_d  = '0;
            per_res_d  = '0;
            duty_res_d = pin_s_q ? 16'd1000 : 16'd0;
            tmo_res_d  = 1'b1;
        end

        if (go_done) begin
            state_d    = StDone;
            high_res_d = high_cnt_q;
            low_res_d  = low_cnt_q;
            per_res_d  = divisor[CNT_W] ? '1 : divisor[CNT_W-1:0];
            duty_res_d = 16'(dq_next);
            tmo_res_d  = 1'b0;
        end
    end
endmodule

// File: tb/tb_dsm_channel_meter.sv
// Bench for dsm_channel_meter: directed table, timeout/abort/reset sequences, random periods.
module tb_dsm_channel_meter;
    logic clk;
    logic rst_n;
    logic start, pin, sel;

    logic        start_a, pin_a, start_b, pin_b;
    logic [15:0] ht_a, lt_a, pt_a, dc_a, ht_b, lt_b, pt_b, dc_b;
    logic        done_a, tmo_a, busy_a, done_b, tmo_b, busy_b;
    logic [15:0] ht, lt, pt, dc;
    logic        done, tmo, busy;

    int n_tests = 0;
    int n_fail  = 0;
    int last_h, last_l, last_p, last_d;

    // Small-timeout instance for most tests; a long-timeout one for the saturation run.
    assign start_a = start & ~sel;
    assign pin_a   = pin & ~sel;
    assign start_b = start & sel;
    assign pin_b   = pin & sel;

    assign ht   = sel ? ht_b : ht_a;
    assign lt   = sel ? lt_b : lt_a;
    assign pt   = sel ? pt_b : pt_a;
    assign dc   = sel ? dc_b : dc_a;
    assign done = sel ? done_b : done_a;
    assign tmo  = sel ? tmo_b : tmo_a;
    assign busy = sel ? busy_b : busy_a;

    dsm_channel_meter #(.CNT_W(16), .TIMEOUT_CYC(32'd1000)) dut_a (
        .clk(clk), .rst_n(rst_n), .measure_start(start_a), .measure_pin(pin_a),
        .high_time(ht_a), .low_time(lt_a), .period_time(pt_a), .duty_cycle(dc_a),
        .measure_done(done_a), .measure_timeout(tmo_a), .busy(busy_a)
    );

    dsm_channel_meter #(.CNT_W(16), .TIMEOUT_CYC(32'd100000)) dut_b (
        .clk(clk), .rst_n(rst_n), .measure_start(start_b), .measure_pin(pin_b),
        .high_time(ht_b), .low_time(lt_b), .period_time(pt_b), .duty_cycle(dc_b),
        .measure_done(done_b), .measure_timeout(tmo_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int h;
        int l;
        bit sat;
        int eh;
        int el;
        int ep;
        int ed;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string tag, input string what, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got %0d expected %0d", tag, what, act, exp);
        end
    endtask

    // Reference: saturate each phase, saturate the sum, per-mille duty from saturated phases.
    task automatic ref_model(input int h, input int l, output int eh, output int el,
                             output int ep, output int ed);
        int maxv;
        maxv = 65535;
        eh = (h > maxv) ? maxv : h;
        el = (l > maxv) ? maxv : l;
        ep = (eh + el > maxv) ? maxv : eh + el;
        ed = (eh * 1000) / (eh + el);
    endtask

    // Assumes start is high and pin low; drives one period and checks results and handshake.
    task automatic drive_and_check(input int h, input int l, input int eh, input int el,
                                   input int ep, input int ed, input string tag);
        repeat (3) @(negedge clk);
        pin = 1'b1;
        repeat (h) @(negedge clk);
        pin = 1'b0;
        repeat (l) @(negedge clk);
        pin = 1'b1;
        // Rise is seen two samples later; done follows 27 cycles after that.
        repeat (28) @(negedge clk);
        chk(tag, "done_early", done, 0);
        chk(tag, "busy_div", busy, 1);
        @(negedge clk);
        chk(tag, "done", done, 1);
        chk(tag, "high_time", ht, eh);
        chk(tag, "low_time", lt, el);
        chk(tag, "period_time", pt, ep);
        chk(tag, "duty_cycle", dc, ed);
        chk(tag, "timeout", tmo, 0);
        chk(tag, "busy_done", busy, 0);
        repeat (3) @(negedge clk);
        chk(tag, "done_hold", done, 1);
        start = 1'b0;
        @(negedge clk);
        chk(tag, "done_clear", done, 0);
        last_h = eh;
        last_l = el;
        last_p = ep;
        last_d = ed;
    endtask

    task automatic measure(input int h, input int l, input int eh, input int el,
                           input int ep, input int ed, input string tag);
        start = 1'b0;
        pin   = 1'b0;
        repeat (4) @(negedge clk);
        chk(tag, "busy_idle", busy, 0);
        start = 1'b1;
        drive_and_check(h, l, eh, el, ep, ed, tag);
    endtask

    task automatic timeout_case(input logic level, input int exp_duty, input string tag);
        int k;
        bit seen;
        sel   = 1'b0;
        start = 1'b0;
        pin   = level;
        repeat (4) @(negedge clk);
        start = 1'b1;
        seen  = 1'b0;
        k     = 0;
        while (!seen && k < 1100) begin
            @(negedge clk);
            k++;
            if (done) seen = 1'b1;
        end
        chk(tag, "done_seen", seen, 1);
        chk(tag, "latency_window", (k >= 1000 && k <= 1003), 1);
        chk(tag, "timeout", tmo, 1);
        chk(tag, "high_time", ht, 0);
        chk(tag, "low_time", lt, 0);
        chk(tag, "period_time", pt, 0);
        chk(tag, "duty_cycle", dc, exp_duty);
        start = 1'b0;
        @(negedge clk);
        chk(tag, "done_clear", done, 0);
    endtask

    initial begin
        repeat (200000) @(negedge clk);
        $display("FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int eh, el, ep, ed, h, l;

        vecs[0] = '{h: 10,    l: 30, sat: 1'b0, eh: 10,    el: 30, ep: 40,    ed: 250};
        vecs[1] = '{h: 1,     l: 99, sat: 1'b0, eh: 1,     el: 99, ep: 100,   ed: 10};
        vecs[2] = '{h: 1,     l: 1,  sat: 1'b0, eh: 1,     el: 1,  ep: 2,     ed: 500};
        vecs[3] = '{h: 3,     l: 7,  sat: 1'b0, eh: 3,     el: 7,  ep: 10,    ed: 300};
        vecs[4] = '{h: 7,     l: 3,  sat: 1'b0, eh: 7,     el: 3,  ep: 10,    ed: 700};
        vecs[5] = '{h: 200,   l: 1,  sat: 1'b0, eh: 200,   el: 1,  ep: 201,   ed: 995};
        vecs[6] = '{h: 70000, l: 10, sat: 1'b1, eh: 65535, el: 10, ep: 65535, ed: 999};

        sel   = 1'b0;
        start = 1'b0;
        pin   = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset", "done", done, 0);
        chk("reset", "busy", busy, 0);
        chk("reset", "high_time", ht, 0);
        chk("reset", "duty_cycle", dc, 0);
        chk("reset", "timeout", tmo, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed table; the saturation row runs on the long-timeout instance.
        for (int i = 0; i < 6; i++) begin
            sel = vecs[i].sat;
            measure(vecs[i].h, vecs[i].l, vecs[i].eh, vecs[i].el, vecs[i].ep, vecs[i].ed,
                    $sformatf("vec%0d", i));
        end

        timeout_case(1'b1, 1000, "tmo_high");
        timeout_case(1'b0, 0, "tmo_low");

        // Abort during HIGH: no done, previous results untouched, then a fresh run.
        sel = 1'b0;
        measure(10, 30, 10, 30, 40, 250, "pre_abort");
        start = 1'b0;
        pin   = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        repeat (3) @(negedge clk);
        pin = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort", "busy_high", busy, 1);
        start = 1'b0;
        @(negedge clk);
        chk("abort", "busy_after", busy, 0);
        repeat (5) @(negedge clk);
        chk("abort", "done", done, 0);
        chk("abort", "high_time", ht, last_h);
        chk("abort", "low_time", lt, last_l);
        chk("abort", "period_time", pt, last_p);
        chk("abort", "duty_cycle", dc, last_d);
        measure(20, 20, 20, 20, 40, 500, "post_abort");

        // Reset in the middle of the divide, start left high across release.
        start = 1'b0;
        pin   = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        repeat (3) @(negedge clk);
        pin = 1'b1;
        repeat (12) @(negedge clk);
        pin = 1'b0;
        repeat (36) @(negedge clk);
        pin = 1'b1;
        repeat (12) @(negedge clk);
        chk("rst_div", "busy_before", busy, 1);
        rst_n = 1'b0;
        pin   = 1'b0;
        #1;
        chk("rst_div", "high_time", ht, 0);
        chk("rst_div", "low_time", lt, 0);
        chk("rst_div", "period_time", pt, 0);
        chk("rst_div", "duty_cycle", dc, 0);
        chk("rst_div", "done", done, 0);
        chk("rst_div", "busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_div", "busy_restart", busy, 1);
        chk("rst_div", "done_restart", done, 0);
        drive_and_check(15, 45, 15, 45, 60, 250, "rst_div_run");

        // Random periods against the reference model.
        for (int i = 0; i < 20; i++) begin
            h = $urandom_range(1, 150);
            l = $urandom_range(1, 150);
            ref_model(h, l, eh, el, ep, ed);
            measure(h, l, eh, el, ep, ed, $sformatf("rand%0d_h%0d_l%0d", i, h, l));
        end

        // Counter saturation on the long-timeout instance.
        sel = vecs[6].sat;
        measure(vecs[6].h, vecs[6].l, vecs[6].eh, vecs[6].el, vecs[6].ep, vecs[6].ed, "vec6");
        ref_model(vecs[6].h, vecs[6].l, eh, el, ep, ed);
        chk("sat_model", "duty_cycle", dc, ed);
        sel = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dsm_channel_meter.md
Name: dsm_channel_meter

Overview:
- Single-channel digital-signal measurement engine; 8 instances form the multichannel DSM array that serves the DSM command handler (one per dsm_signal_in bit).
- Synchronises one pin and waits for a rising edge. Times one full high + low period in clk cycles, computes the duty cycle in per-mille with a serial divider, then holds results with a done flag.
- Handshake matches the handler: the handler holds measure_start high until it sees measure_done, then drops it.

Parameters:
- CNT_W, 16: width of the high, low and period result counters.
- TIMEOUT_CYC, 32'd50_000_000: maximum cycles without an expected edge before a timeout ends the measurement.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- measure_start  in  1  level request: rising level in IDLE starts a measurement; low aborts/acknowledges.
- measure_pin  in  1  asynchronous input signal.
- high_time  out  CNT_W  high-phase length, cycles.
- low_time  out  CNT_W  low-phase length, cycles.
- period_time  out  CNT_W  high_time+low_time, saturating.
- duty_cycle  out  16  floor(high*1000/(high+low)), range 0..1000.
- measure_done  out  1  results valid; held until measure_start low.
- measure_timeout  out  1  last measurement ended by timeout; valid with measure_done.
- busy  out  1  high in any state except IDLE/DONE.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, synchroniser flops 0.
- Input path: 2-FF synchroniser to pin_s, plus a registered pin_d.
  - rise = pin_s & ~pin_d; fall = ~pin_s & pin_d.
  - Fixed 3-cycle latency on all edges, so durations are exact.
- States:
  - IDLE: measure_start=1 -> WAIT_RISE. Clear counters and timeout counter; keep previous result outputs unchanged.
  - WAIT_RISE: on rise -> HIGH with high_cnt=1.
  - HIGH: while pin_s=1, high_cnt increments, saturating at all-ones. On fall -> LOW with low_cnt=1.
  - LOW: low_cnt increments, saturating. On rise -> DIV.
  - DIV: restoring serial divide.
    - Dividend = high_cnt*1000 (26 bits); divisor = high_cnt+low_cnt (CNT_W+1 bits, unsaturated sum).
    - One quotient bit per cycle, exactly 26 cycles.
    - Then load high_time, low_time, period_time (sum saturated to CNT_W), duty_cycle (quotient) and measure_timeout=0 -> DONE.
  - DONE: measure_done=1. Outputs stable. measure_start=0 -> IDLE with measure_done=0 the next cycle.
- Latency: the cycle after the closing rise is first DIV cycle; measure_done is high 27 cycles after the closing rise is detected.
- Timeout:
  - A 32-bit counter is cleared on entry to WAIT_RISE and on every rise/fall; it increments in WAIT_RISE/HIGH/LOW.
  - On reaching TIMEOUT_CYC -> DONE with high_time=low_time=period_time=0, measure_timeout=1.
  - duty_cycle=1000 if pin_s=1 at that moment, else 0.
  - No divide is performed.
- Abort: measure_start=0 in WAIT_RISE/HIGH/LOW/DIV -> IDLE next cycle. Result outputs keep their prior values; measure_done stays 0.
- Simultaneous events: timeout and edge in the same cycle -> the edge wins. measure_start=0 has priority over edge/timeout.
- A new measurement needs measure_start to go low and high again; start held continuously high after DONE does not retrigger.
- Division by zero is impossible: the divisor is ≥2 whenever DIV is entered.

Test Plan:
- Square wave, 10 cycles high / 30 low, start asserted mid-low -> high_time=10, low_time=30, period_time=40, duty_cycle=250, timeout=0. done exactly 27 cycles after the second synced rise.
- Pin held 1, TIMEOUT_CYC=1000 -> after 1000 cycles: done=1, timeout=1, all times 0, duty=1000. Pin held 0 -> same, with duty=0.
- 1-cycle high glitch then 99 low -> high=1, low=99, period=100, duty=10.
- CNT_W=16, high 70000 / low 10 -> high_time=0xFFFF, low=10, period=0xFFFF, duty=floor(65535000/65545)=999.
- Drop measure_start during HIGH -> done never asserts, previous results unchanged, busy=0 one cycle later. Re-raise start -> fresh correct measurement.
- Assert rst_n=0 during DIV -> all outputs 0 immediately. With start held high after reset release, measurement starts from WAIT_RISE.
